avalon_st_sink: RTL and testbench

Avalon-ST sink stage placed directly downstream of the byte-stream source: it drives `in_ready`, captures beats under a configurable ready latency into a small FIFO, and re-presents them on a first-word-fall-through valid/ready output port. It frames the stream into fixed-length packets: it counts accepted beats, drains the FIFO at packet end, and pulses `pkt_done`. It also flags protocol violations where the source sends while the FIFO is full.

---
 rtl/avalon_st_pkg.sv | 18 +
 rtl/st_fifo.sv | 70 +++++++
 rtl/avalon_st_sink.sv | 148 ++++++++++++++
 tb/tb_avalon_st_sink.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_pkg.sv
// Shared types and constants for the Avalon-ST sink and its FIFO.
package avalon_st_pkg;

  // Packet framing states of the sink.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Largest supported ready latency.
  localparam int unsigned RL_MAX = 1;

  // Default beat width.
  localparam int unsigned DATA_W_DEFAULT = 8;

endpackage

// File: rtl/st_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always visible on dout.
// Push when full and pop when empty are ignored. DEPTH must be a power of two.
module st_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Storage write; cleared on reset so the output reads 0 after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/avalon_st_sink.sv
// Avalon-ST sink: registered in_ready with ready latency 0 or 1, FWFT output through st_fifo,
// fixed-length packet framing with a one-cycle pkt_done pulse, and a sticky overflow flag.
// Optional feature: define AVALON_SINK_CHECKSUM_EN to build the per-packet byte-sum on
// checksum; otherwise checksum is tied to 0.
module avalon_st_sink
  import avalon_st_pkg::*;
#(
  parameter int unsigned DATA_W        = DATA_W_DEFAULT,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned READY_LATENCY = 1,
  parameter int unsigned PKT_LEN       = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [7:0]        beat_count,
  output logic              pkt_done,
  output logic              overflow,
  output logic [7:0]        checksum
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e        r_state;
  state_e        w_state_d;
  logic          r_in_ready;
  logic          r_ready_d1;
  logic [7:0]    r_beat_count;
  logic          r_overflow;
  logic          w_permit;
  logic          w_accept;
  logic          w_arrive;
  logic          w_counted;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_count_next;

  // With latency 1 the permission for this cycle's beat is last cycle's in_ready.
  assign w_permit  = (READY_LATENCY >= RL_MAX) ? r_ready_d1 : r_in_ready;
  assign w_accept  = in_valid && w_permit;
  // With latency 1 any beat on the bus is a real transfer, permitted or not.
  assign w_arrive  = (READY_LATENCY >= RL_MAX) ? in_valid : w_accept;
  assign w_counted = w_accept && (r_state == S_RECV);
  assign w_push    = w_accept && !w_full;
  assign w_pop     = !w_empty && out_ready;

  st_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    (in_data),
    .dout   (out_data),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  // Occupancy after the coming edge, used to look ahead for in_ready.
  always_comb begin
    w_count_next = {1'b0, w_count};
    if (w_push && !w_pop) w_count_next = w_count_next + 1'b1;
    if (w_pop && !w_push) w_count_next = w_count_next - 1'b1;
  end

  // Packet framing next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:  w_state_d = S_RECV;
      S_RECV:  if (w_counted && ((r_beat_count + 8'd1) == 8'(PKT_LEN))) w_state_d = S_DRAIN;
      S_DRAIN: if (w_count == '0) w_state_d = S_DONE;
      S_DONE:  w_state_d = S_RECV;
      default: w_state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_d;
  end

  // Ready generation; IDLE holds it low one more edge so the source starts after settle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_in_ready <= 1'b0;
      r_ready_d1 <= 1'b0;
    end else begin
      r_in_ready <= (w_state_d == S_RECV) && (r_state != S_IDLE) &&
                    ((32'(w_count_next) + READY_LATENCY) < DEPTH);
      r_ready_d1 <= r_in_ready;
    end
  end

  // Beats counted in the current packet; cleared as DONE completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 r_beat_count <= '0;
    else if (r_state == S_DONE)  r_beat_count <= '0;
    else if (w_counted)          r_beat_count <= r_beat_count + 8'd1;
  end

  // Sticky flag for a beat landing on a full FIFO; the beat itself is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 r_overflow <= 1'b0;
    else if (w_arrive && w_full) r_overflow <= 1'b1;
  end

`ifdef AVALON_SINK_CHECKSUM_EN
  logic [7:0] r_acc;
  logic [7:0] r_checksum;

  // Byte-sum of counted beats, published and restarted at packet end.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc      <= '0;
      r_checksum <= '0;
    end else if (r_state == S_DONE) begin
      r_checksum <= r_acc;
      r_acc      <= '0;
    end else if (w_counted) begin
      r_acc <= r_acc + 8'(in_data);
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign in_ready   = r_in_ready;
  assign out_valid  = !w_empty;
  assign beat_count = r_beat_count;
  assign pkt_done   = (r_state == S_DONE);
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_avalon_st_sink.sv
// Scoreboard bench for avalon_st_sink: DUT a uses ready latency 1, DUT b ready latency 0.
module tb_avalon_st_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT a (RL=1)
  logic       a_resetn, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       a_pkt_done, a_overflow;
  logic [7:0] a_in_data, a_out_data, a_beat_count, a_checksum;
  // DUT b (RL=0)
  logic       b_resetn, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic       b_pkt_done, b_overflow;
  logic [7:0] b_in_data, b_out_data, b_beat_count, b_checksum;

  avalon_st_sink #(.DATA_W(8), .DEPTH(4), .READY_LATENCY(1), .PKT_LEN(3)) u_dut_a (
    .clk(clk), .resetn(a_resetn), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(a_out_ready), .beat_count(a_beat_count), .pkt_done(a_pkt_done),
    .overflow(a_overflow), .checksum(a_checksum)
  );

  avalon_st_sink #(.DATA_W(8), .DEPTH(4), .READY_LATENCY(0), .PKT_LEN(3)) u_dut_b (
    .clk(clk), .resetn(b_resetn), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready), .beat_count(b_beat_count), .pkt_done(b_pkt_done),
    .overflow(b_overflow), .checksum(b_checksum)
  );

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } beat_t;

  beat_t      sb_a[$];
  beat_t      sb_b[$];
  logic [7:0] pk_a[$];
  logic [7:0] pk_b[$];
  int n_cmp = 0;
  int n_bad = 0;
  int a_pkts = 0;
  int b_pkts = 0;
  bit lat_chk = 1'b0;
  bit a_ck_pend = 1'b0;
  bit b_ck_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [7:0] ck_exp(input logic [7:0] s);
`ifdef AVALON_SINK_CHECKSUM_EN
    return s;
`else
    return 8'd0;
`endif
  endfunction

  // Monitor a: pop the scoreboard on every output transfer, check checksum after pkt_done.
  always @(negedge clk) begin
    beat_t e;
    if (a_out_valid && a_out_ready) begin
      if (sb_a.size() == 0) begin
        fail($sformatf("a_unexpected_beat data=%0h", a_out_data));
      end else begin
        e = sb_a.pop_front();
        chk("a_data", a_out_data, e.d);
        if (lat_chk) chk("a_latency", cyc - e.cyc, 1);
      end
    end
    if (a_ck_pend) begin
      a_ck_pend = 1'b0;
      chk("a_pkt_done_width", a_pkt_done, 0);
      if (pk_a.size() == 0) fail("a_unexpected_pkt_done");
      else chk("a_checksum", a_checksum, pk_a.pop_front());
      a_pkts++;
    end else if (a_pkt_done) begin
      a_ck_pend = 1'b1;
    end
  end

  // Monitor b.
  always @(negedge clk) begin
    beat_t e;
    if (b_out_valid && b_out_ready) begin
      if (sb_b.size() == 0) begin
        fail($sformatf("b_unexpected_beat data=%0h", b_out_data));
      end else begin
        e = sb_b.pop_front();
        chk("b_data", b_out_data, e.d);
      end
    end
    if (b_ck_pend) begin
      b_ck_pend = 1'b0;
      chk("b_pkt_done_width", b_pkt_done, 0);
      if (pk_b.size() == 0) fail("b_unexpected_pkt_done");
      else chk("b_checksum", b_checksum, pk_b.pop_front());
      b_pkts++;
    end else if (b_pkt_done) begin
      b_ck_pend = 1'b1;
    end
  end

  // RL=1 source: a beat goes out in cycle t only if in_ready was high in cycle t-1.
  task automatic send_a(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input int nb, input bit extra, input logic [7:0] xd);
    logic [7:0] d[3];
    logic [7:0] s;
    int n = 0;
    int n_prev = 0;
    int guard = 0;
    bit perm;
    d[0] = d0; d[1] = d1; d[2] = d2;
    while (n < nb && guard < 50) begin
      @(negedge clk);
      chk("a_beat_count", a_beat_count, n_prev);
      n_prev = n;
      perm = a_in_ready;
      @(posedge clk); #1;
      if (perm) begin
        a_in_valid = 1'b1;
        a_in_data  = d[n];
        sb_a.push_back('{d[n], cyc});
        n++;
      end else begin
        a_in_valid = 1'b0;
      end
      guard++;
    end
    if (n < nb) fail("a_send_timeout");
    @(negedge clk);
    chk("a_beat_count", a_beat_count, n_prev);
    perm = a_in_ready;
    @(posedge clk); #1;
    if (extra) begin
      chk("a_drain_first_permit", perm, 1);
      if (perm) begin
        a_in_valid = 1'b1;
        a_in_data  = xd;
        sb_a.push_back('{xd, cyc});
      end else begin
        a_in_valid = 1'b0;
      end
    end else begin
      a_in_valid = 1'b0;
    end
    if (nb == 3) begin
      s = d0 + d1 + d2;
      pk_a.push_back(ck_exp(s));
    end
    @(negedge clk);
    chk("a_beat_count_end", a_beat_count, nb);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic wait_pkts_a(input int target);
    int guard = 0;
    while (a_pkts < target && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (a_pkts < target) fail("a_pkt_timeout");
  endtask

  task automatic run_a();
    a_resetn = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_rst_in_ready", a_in_ready, 0);
    chk("a_rst_out_valid", a_out_valid, 0);
    chk("a_rst_out_data", a_out_data, 0);
    chk("a_rst_beat_count", a_beat_count, 0);
    chk("a_rst_pkt_done", a_pkt_done, 0);
    chk("a_rst_overflow", a_overflow, 0);
    chk("a_rst_checksum", a_checksum, 0);
    a_resetn = 1'b1;
    @(negedge clk);
    chk("a_in_ready_edge1", a_in_ready, 0);
    @(negedge clk);
    chk("a_in_ready_edge2", a_in_ready, 1);
    chk("a_out_valid_edge2", a_out_valid, 0);

    // Nominal packet with a free-running sink.
    a_out_ready = 1'b1;
    lat_chk = 1'b1;
    send_a(8'd4, 8'd5, 8'd6, 3, 1'b0, 8'h00);
    wait_pkts_a(1);
    @(negedge clk);
    chk("a_beat_count_cleared", a_beat_count, 0);

    // Backpressure: three counted beats plus one in the first DRAIN cycle fill the FIFO.
    lat_chk = 1'b0;
    a_out_ready = 1'b0;
    send_a(8'd7, 8'd8, 8'd9, 3, 1'b1, 8'd10);
    @(negedge clk);
    chk("a_bp_in_ready", a_in_ready, 0);
    chk("a_bp_out_valid", a_out_valid, 1);
    chk("a_bp_head", a_out_data, 8'd7);
    chk("a_bp_no_overflow", a_overflow, 0);

    // Protocol violation onto the full FIFO.
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = 8'hAA;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("a_overflow_set", a_overflow, 1);
    a_out_ready = 1'b1;
    wait_pkts_a(2);
    @(negedge clk);
    chk("a_overflow_sticky", a_overflow, 1);

    // Reset after two of three beats.
    a_out_ready = 1'b0;
    send_a(8'd1, 8'd2, 8'd3, 2, 1'b0, 8'h00);
    @(negedge clk);
    chk("a_mid_out_valid", a_out_valid, 1);
    #2;
    a_resetn = 1'b0;
    #1;
    chk("a_mid_rst_out_valid", a_out_valid, 0);
    chk("a_mid_rst_beat_count", a_beat_count, 0);
    chk("a_mid_rst_overflow", a_overflow, 0);
    chk("a_mid_rst_in_ready", a_in_ready, 0);
    sb_a.delete();
    @(negedge clk);
    a_resetn = 1'b1;
    a_out_ready = 1'b1;
    lat_chk = 1'b1;
    send_a(8'd1, 8'd2, 8'd3, 3, 1'b0, 8'h00);
    wait_pkts_a(3);
    chk("a_sb_empty", sb_a.size(), 0);
  endtask

  // RL=0 source: in_valid held high, data advances only on cycles with in_ready high.
  task automatic run_b();
    logic [7:0] nxt = 8'd1;
    logic [7:0] s = 8'd0;
    int nacc = 0;
    int guard = 0;
    b_resetn = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("b_rst_in_ready", b_in_ready, 0);
    b_resetn = 1'b1;
    while (nacc < 9 && guard < 200) begin
      @(posedge clk); #1;
      b_in_valid  = 1'b1;
      b_in_data   = nxt;
      b_out_ready = (guard % 3) != 2;
      @(negedge clk);
      if (b_in_ready) begin
        sb_b.push_back('{nxt, cyc});
        s = s + nxt;
        nxt = nxt + 8'd1;
        nacc++;
        if (nacc % 3 == 0) begin
          pk_b.push_back(ck_exp(s));
          s = 8'd0;
        end
      end
      guard++;
    end
    if (nacc < 9) fail("b_send_timeout");
    @(posedge clk); #1;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    guard = 0;
    while (b_pkts < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (b_pkts < 3) fail("b_pkt_timeout");
    chk("b_sb_empty", sb_b.size(), 0);
    chk("b_overflow", b_overflow, 0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
